// File: rtl/mem_bus_pkg.sv
// Shared encodings for the instruction/data memory bus arbiter and its tag FIFO.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package mem_bus_pkg;

  localparam int MAX_OUT_DEF = 2;

  localparam logic OWN_INST = 1'b0;
  localparam logic OWN_DATA = 1'b1;

  localparam logic [1:0] SZ_B = 2'd0;
  localparam logic [1:0] SZ_H = 2'd1;
  localparam logic [1:0] SZ_W = 2'd2;

  // One entry per outstanding bus request, kept in issue order.
  typedef struct packed {
    logic owner;    // OWN_INST or OWN_DATA
    logic discard;  // response must be dropped (cancelled fetch)
  } tag_t;

endpackage

// File: rtl/mem_tag_fifo.sv
// Tag FIFO: records owner/discard of each outstanding bus request in issue order.
// Latency: push/pop take effect at the next clk edge; head is a registered read.
// Backpressure: push ignored while full, pop ignored while empty.
// Ports: clk, rstn (async active-low); push_i/push_tag_i, pop_i, flush_i (mark
//        inst entries as discard); full_o, empty_o, head_o (oldest entry).
module mem_tag_fifo
  import mem_bus_pkg::*;
#(
  parameter int DEPTH = MAX_OUT_DEF
) (
  input  logic clk,
  input  logic rstn,
  input  logic push_i,
  input  tag_t push_tag_i,
  input  logic pop_i,
  input  logic flush_i,
  output logic full_o,
  output logic empty_o,
  output tag_t head_o
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  tag_t             mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_push, do_pop;

  assign full_o  = (count_q == CNT_W'(DEPTH));
  assign empty_o = (count_q == '0);
  assign head_o  = mem_q[rd_ptr_q];
  assign do_push = push_i & ~full_o;
  assign do_pop  = pop_i & ~empty_o;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) begin
      wr_ptr_d = (wr_ptr_q == PTR_W'(DEPTH - 1)) ? '0 : wr_ptr_q + PTR_W'(1);
    end
    if (do_pop) begin
      rd_ptr_d = (rd_ptr_q == PTR_W'(DEPTH - 1)) ? '0 : rd_ptr_q + PTR_W'(1);
    end
    unique case ({do_push, do_pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      // Marking free slots too is harmless: a push overwrites the whole tag.
      for (int i = 0; i < DEPTH; i++) begin
        if (flush_i && mem_q[i].owner == OWN_INST) begin
          mem_q[i].discard <= 1'b1;
        end
      end
      // Placed after the flush loop so a new tag always lands intact.
      if (do_push) begin
        mem_q[wr_ptr_q] <= push_tag_i;
      end
    end
  end

endmodule

// File: rtl/mem_bus_arbiter.sv
// Arbitrates fetch and load/store onto one SRAM-like bus (data has priority) and
// routes in-order responses back. Latency: addr_ok/data_ok combinational, zero added.
// Backpressure: bus_req drops while MAX_OUT requests are outstanding.
// Ports: clk, rstn; flush; inst_* fetch side; data_* load/store side; bus_* bridge
//        side. All outputs are forced to 0 while rstn is low.
module mem_bus_arbiter
  import mem_bus_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int MAX_OUT = MAX_OUT_DEF
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              flush,
  input  logic              inst_req,
  input  logic [ADDR_W-1:0] inst_addr,
  output logic              inst_addr_ok,
  output logic              inst_data_ok,
  output logic [DATA_W-1:0] inst_rdata,
  input  logic              data_req,
  input  logic              data_wr,
  input  logic [1:0]        data_size,
  input  logic [3:0]        data_wstrb,
  input  logic [ADDR_W-1:0] data_addr,
  input  logic [DATA_W-1:0] data_wdata,
  output logic              data_addr_ok,
  output logic              data_data_ok,
  output logic [DATA_W-1:0] data_rdata,
  output logic              bus_req,
  output logic              bus_wr,
  output logic [1:0]        bus_size,
  output logic [3:0]        bus_wstrb,
  output logic [ADDR_W-1:0] bus_addr,
  output logic [DATA_W-1:0] bus_wdata,
  input  logic              bus_addr_ok,
  input  logic              bus_data_ok,
  input  logic [DATA_W-1:0] bus_rdata
);

  logic fifo_full, fifo_empty;
  logic accept, pop;
  tag_t push_tag, head;

  always_comb begin
    bus_req   = 1'b0;
    bus_wr    = 1'b0;
    bus_size  = SZ_B;
    bus_wstrb = '0;
    bus_addr  = '0;
    bus_wdata = '0;
    if (rstn) begin
      bus_req = (inst_req | data_req) & ~fifo_full;
      if (data_req) begin
        bus_wr    = data_wr;
        bus_size  = data_size;
        bus_wstrb = data_wstrb;
        bus_addr  = data_addr;
        bus_wdata = data_wdata;
      end else begin
        bus_size = SZ_W;
        bus_addr = inst_addr;
      end
    end
  end

  assign accept       = bus_req & bus_addr_ok;
  assign data_addr_ok = accept & data_req;
  assign inst_addr_ok = accept & ~data_req;

  // A fetch accepted during a flush belongs to the cancelled stream.
  assign push_tag.owner   = data_req ? OWN_DATA : OWN_INST;
  assign push_tag.discard = ~data_req & flush;

  // Responses with nothing outstanding are a bridge error and are ignored.
  assign pop          = rstn & bus_data_ok & ~fifo_empty;
  assign data_data_ok = pop & (head.owner == OWN_DATA) & ~head.discard;
  // Same-cycle flush cancels the fetch response being popped right now.
  assign inst_data_ok = pop & (head.owner == OWN_INST) & ~head.discard & ~flush;

  assign inst_rdata = rstn ? bus_rdata : '0;
  assign data_rdata = rstn ? bus_rdata : '0;

  mem_tag_fifo #(.DEPTH(MAX_OUT)) u_fifo (
    .clk        (clk),
    .rstn       (rstn),
    .push_i     (accept),
    .push_tag_i (push_tag),
    .pop_i      (pop),
    .flush_i    (flush),
    .full_o     (fifo_full),
    .empty_o    (fifo_empty),
    .head_o     (head)
  );

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Self-checking bench for mem_bus_arbiter: directed scenarios then random traffic,
// checked against a queue model of outstanding requests.
// Inputs change at negedge; outputs are sampled a few ns later, well before posedge.
module tb_mem_bus_arbiter;

  localparam int MAX_OUT = 2;

  logic        clk, rstn, flush;
  logic        inst_req, inst_addr_ok, inst_data_ok;
  logic [31:0] inst_addr, inst_rdata;
  logic        data_req, data_wr, data_addr_ok, data_data_ok;
  logic [1:0]  data_size;
  logic [3:0]  data_wstrb;
  logic [31:0] data_addr, data_wdata, data_rdata;
  logic        bus_req, bus_wr, bus_addr_ok, bus_data_ok;
  logic [1:0]  bus_size;
  logic [3:0]  bus_wstrb;
  logic [31:0] bus_addr, bus_wdata, bus_rdata;

  int errors = 0;
  int checks = 0;

  typedef struct {
    bit own;   // 1 = data request
    bit canc;  // fetch cancelled by a flush
  } ent_t;
  ent_t mq[$];

  mem_bus_arbiter #(.ADDR_W(32), .DATA_W(32), .MAX_OUT(MAX_OUT)) dut (
    .clk(clk), .rstn(rstn), .flush(flush),
    .inst_req(inst_req), .inst_addr(inst_addr), .inst_addr_ok(inst_addr_ok),
    .inst_data_ok(inst_data_ok), .inst_rdata(inst_rdata),
    .data_req(data_req), .data_wr(data_wr), .data_size(data_size),
    .data_wstrb(data_wstrb), .data_addr(data_addr), .data_wdata(data_wdata),
    .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok), .data_rdata(data_rdata),
    .bus_req(bus_req), .bus_wr(bus_wr), .bus_size(bus_size), .bus_wstrb(bus_wstrb),
    .bus_addr(bus_addr), .bus_wdata(bus_wdata),
    .bus_addr_ok(bus_addr_ok), .bus_data_ok(bus_data_ok), .bus_rdata(bus_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    flush = 0; inst_req = 0; data_req = 0; data_wr = 0; data_size = 2'd0;
    data_wstrb = 4'h0; bus_addr_ok = 0; bus_data_ok = 0;
  endtask

  // Checks one cycle against the model, advances the model, moves to next negedge.
  task automatic tick(input string tag);
    bit   full_m, e_breq, e_acc, e_pop, e_ido, e_ddo;
    ent_t h;
    ent_t n;
    #2;
    if (!rstn) mq.delete();
    chk({tag, ".count"}, 32'(dut.u_fifo.count_q), 32'(mq.size()));
    full_m = (mq.size() >= MAX_OUT);
    e_breq = rstn && (inst_req || data_req) && !full_m;
    e_acc  = e_breq && bus_addr_ok;
    e_pop  = rstn && bus_data_ok && (mq.size() > 0);
    h.own = 0; h.canc = 0;
    if (e_pop) h = mq[0];
    e_ido = e_pop && !h.own && !h.canc && !flush;
    e_ddo = e_pop && h.own;
    chk({tag, ".bus_req"}, 32'(bus_req), 32'(e_breq));
    chk({tag, ".iaok"}, 32'(inst_addr_ok), 32'(e_acc && !data_req));
    chk({tag, ".daok"}, 32'(data_addr_ok), 32'(e_acc && data_req));
    chk({tag, ".idok"}, 32'(inst_data_ok), 32'(e_ido));
    chk({tag, ".ddok"}, 32'(data_data_ok), 32'(e_ddo));
    if (e_breq) begin
      chk({tag, ".addr"}, bus_addr, data_req ? data_addr : inst_addr);
      chk({tag, ".wr"}, 32'(bus_wr), 32'(data_req && data_wr));
      chk({tag, ".size"}, 32'(bus_size), data_req ? 32'(data_size) : 32'd2);
      chk({tag, ".wstrb"}, 32'(bus_wstrb), data_req ? 32'(data_wstrb) : 32'd0);
      if (data_req) chk({tag, ".wdata"}, bus_wdata, data_wdata);
    end
    if (e_ido) chk({tag, ".irdata"}, inst_rdata, bus_rdata);
    if (e_ddo) chk({tag, ".drdata"}, data_rdata, bus_rdata);
    if (!rstn) begin
      chk({tag, ".rst_addr"}, bus_addr, 32'd0);
      chk({tag, ".rst_rdata"}, inst_rdata | data_rdata, 32'd0);
      chk({tag, ".rst_misc"}, {26'd0, bus_wr, bus_size, bus_wstrb[2:0]}, 32'd0);
    end
    if (e_pop) void'(mq.pop_front());
    if (rstn && flush) begin
      foreach (mq[i]) if (!mq[i].own) mq[i].canc = 1;
    end
    if (e_acc) begin
      n.own  = data_req;
      n.canc = !data_req && flush;
      mq.push_back(n);
    end
    @(negedge clk);
  endtask

  initial begin
    rstn = 0; idle();
    inst_addr = 32'h0; data_addr = 32'h0; data_wdata = 32'h0; bus_rdata = 32'h0;

    // Reset: outputs forced low even with requests pending.
    @(negedge clk);
    inst_req = 1; data_req = 1; bus_addr_ok = 1; bus_data_ok = 1;
    bus_rdata = 32'hFFFF_FFFF; data_addr = 32'h1234_5678;
    tick("rst");
    idle(); rstn = 1;
    tick("rel");

    // Both requesters high: data wins, strobes forwarded.
    inst_req = 1; inst_addr = 32'h1C00_0000;
    data_req = 1; data_wr = 1; data_size = 2'd1; data_wstrb = 4'b0011;
    data_addr = 32'h0000_1002; data_wdata = 32'hCAFE_BEEF; bus_addr_ok = 1;
    #1;
    chk("prio.daok", 32'(data_addr_ok), 32'd1);
    chk("prio.iaok", 32'(inst_addr_ok), 32'd0);
    chk("prio.wstrb", 32'(bus_wstrb), 32'h3);
    tick("prio");
    idle(); bus_data_ok = 1; bus_rdata = 32'h0;
    tick("prio_rsp");

    // Fetch, idle, response two cycles later.
    idle(); inst_req = 1; inst_addr = 32'h1C00_0000; bus_addr_ok = 1;
    tick("f1");
    idle();
    tick("f1_wait");
    bus_data_ok = 1; bus_rdata = 32'h0280_0C0C;
    #1;
    chk("f1.idok", 32'(inst_data_ok), 32'd1);
    chk("f1.irdata", inst_rdata, 32'h0280_0C0C);
    chk("f1.ddok", 32'(data_data_ok), 32'd0);
    tick("f1_rsp");

    // Fill to MAX_OUT, third fetch held off until a pop, accepted next cycle.
    idle(); inst_req = 1; bus_addr_ok = 1; inst_addr = 32'h1C00_0004;
    tick("full_a");
    inst_addr = 32'h1C00_0008;
    tick("full_b");
    inst_addr = 32'h1C00_000C;
    #1; chk("full.breq", 32'(bus_req), 32'd0);
    tick("full_c");
    bus_data_ok = 1; bus_rdata = 32'h1111_1111;
    #1; chk("full.breq_pop", 32'(bus_req), 32'd0);
    tick("full_pop");
    bus_data_ok = 0;
    #1; chk("full.iaok_after", 32'(inst_addr_ok), 32'd1);
    tick("full_acc");
    idle(); bus_data_ok = 1; bus_rdata = 32'h2222_2222;
    tick("drain1");
    tick("drain2");

    // Fetch in N, flush in N+1, response in N+3: dropped.
    idle(); inst_req = 1; inst_addr = 32'h1C00_0010; bus_addr_ok = 1;
    tick("fl_n");
    idle(); flush = 1;
    tick("fl_n1");
    idle();
    tick("fl_n2");
    bus_data_ok = 1; bus_rdata = 32'h3333_3333;
    #1; chk("fl.idok", 32'(inst_data_ok), 32'd0);
    tick("fl_n3");
    idle();
    #1; chk("fl.count0", 32'(dut.u_fifo.count_q), 32'd0);
    tick("fl_n4");

    // Store, fetch, flush: store acked, fetch response dropped.
    data_req = 1; data_wr = 1; data_size = 2'd2; data_wstrb = 4'hF;
    data_addr = 32'h0000_2000; data_wdata = 32'h5555_AAAA; bus_addr_ok = 1;
    tick("sf_st");
    idle(); inst_req = 1; inst_addr = 32'h1C00_0020; bus_addr_ok = 1;
    tick("sf_f");
    idle(); flush = 1;
    tick("sf_fl");
    idle(); bus_data_ok = 1; bus_rdata = 32'h0;
    #1; chk("sf.ddok", 32'(data_data_ok), 32'd1);
    tick("sf_r1");
    #1; chk("sf.idok", 32'(inst_data_ok), 32'd0);
    tick("sf_r2");

    // Reset with two outstanding, late response afterwards ignored.
    idle(); inst_req = 1; bus_addr_ok = 1;
    tick("rr_a");
    tick("rr_b");
    idle(); bus_data_ok = 1; rstn = 0;
    tick("rr_rst");
    rstn = 1;
    #1;
    chk("rr.idok", 32'(inst_data_ok), 32'd0);
    chk("rr.ddok", 32'(data_data_ok), 32'd0);
    tick("rr_late");
    bus_data_ok = 0;
    tick("rr_idle");

    // Random traffic against the queue model.
    for (int c = 0; c < 400; c++) begin
      inst_req    = ($urandom_range(0, 99) < 55);
      inst_addr   = $urandom;
      data_req    = ($urandom_range(0, 99) < 40);
      data_wr     = $urandom_range(0, 1);
      data_size   = 2'($urandom_range(0, 2));
      data_wstrb  = 4'($urandom);
      data_addr   = $urandom;
      data_wdata  = $urandom;
      bus_addr_ok = ($urandom_range(0, 99) < 60);
      bus_data_ok = ($urandom_range(0, 99) < 50);
      bus_rdata   = $urandom;
      flush       = ($urandom_range(0, 99) < 10);
      tick("rnd");
    end

    idle();
    tick("end");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
